// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared FSM states, pattern codes and coordinate width for the image timing generator
package image_pkg;

  localparam int COORD_W = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HBLANK = 2'd2,
    VBLANK = 2'd3
  } fsmState;

  localparam logic [1:0] PAT_SOLID   = 2'd0;
  localparam logic [1:0] PAT_RAMP    = 2'd1;
  localparam logic [1:0] PAT_CHECKER = 2'd2;
  localparam logic [1:0] PAT_COUNTER = 2'd3;

endpackage

// File: rtl/image_pattern_gen.sv
// rtl/image_pattern_gen.sv - registered RGB888 test-pattern source
// Fed with next-cycle coordinates so its output lines up with the registered strobes.
module image_pattern_gen
  import image_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iActive,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  input  logic [7:0]         iFrame,
  input  logic [1:0]         iPattern,
  output logic [23:0]        oPixel
);

  always_ff @(posedge iClk) begin
    if (iRst || !iActive) begin
      oPixel <= 24'h000000;
    end else begin
      case (iPattern)
        PAT_SOLID:   oPixel <= 24'h808080;
        PAT_RAMP:    oPixel <= {iX[7:0], iX[7:0], iX[7:0]};
        PAT_CHECKER: oPixel <= (iX[3] ^ iY[3]) ? 24'hFFFFFF : 24'h000000;
        default:     oPixel <= {iFrame, iX[7:0], iY[7:0]};
      endcase
    end
  end

endmodule

// File: rtl/image_timing_gen.sv
// rtl/image_timing_gen.sv - camera-style frame/line timing generator with built-in test patterns
module image_timing_gen
  import image_pkg::*;
#(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_BLANK = 160,
  parameter int V_BLANK = 45
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic [1:0]  iPattern,
  output logic        oFrameValid,
  output logic        oLineValid,
  output logic [23:0] oPixel,
  output logic [15:0] oFrameCount
);

  localparam int LINE_LEN = WIDTH + H_BLANK;
  localparam int VB_LEN   = V_BLANK * LINE_LEN;
  localparam int BLANK_W  = $clog2(VB_LEN + 1);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(HEIGHT - 1);
  localparam logic [BLANK_W-1:0] HB_LAST = BLANK_W'(H_BLANK - 1);
  localparam logic [BLANK_W-1:0] VB_LAST = BLANK_W'(VB_LEN - 1);

  fsmState            state, nxtState;
  logic [COORD_W-1:0] x, y, nxtX, nxtY;
  logic [BLANK_W-1:0] blankCnt, nxtBlank;
  logic [1:0]         patSel, nxtPat;
  logic [15:0]        frameCount, nxtCount;
  logic               nxtFv, nxtLv;

  // Next-cycle values are computed here so the pattern source can register
  // a pixel for exactly the cycle in which oLineValid goes high.
  always_comb begin
    nxtState = state;
    nxtX     = x;
    nxtY     = y;
    nxtBlank = blankCnt;
    nxtFv    = oFrameValid;
    nxtLv    = oLineValid;
    nxtPat   = patSel;
    nxtCount = frameCount;
    case (state)
      IDLE: begin
        if (iEnable) begin
          nxtState = ACTIVE;
          nxtX     = '0;
          nxtY     = '0;
          nxtFv    = 1'b1;
          nxtLv    = 1'b1;
          nxtPat   = iPattern;
        end
      end
      ACTIVE: begin
        if (x == X_LAST) begin
          nxtState = HBLANK;
          nxtBlank = '0;
          nxtLv    = 1'b0;
        end else begin
          nxtX = x + 1'b1;
        end
      end
      HBLANK: begin
        if (blankCnt == HB_LAST) begin
          if (y < Y_LAST) begin
            nxtState = ACTIVE;
            nxtX     = '0;
            nxtY     = y + 1'b1;
            nxtLv    = 1'b1;
          end else begin
            // Frame-valid spans the last line's blanking, then drops here.
            nxtState = VBLANK;
            nxtBlank = '0;
            nxtFv    = 1'b0;
            nxtCount = frameCount + 1'b1;
          end
        end else begin
          nxtBlank = blankCnt + 1'b1;
        end
      end
      VBLANK: begin
        if (blankCnt == VB_LAST) begin
          nxtBlank = '0;
          nxtX     = '0;
          nxtY     = '0;
          if (iEnable) begin
            nxtState = ACTIVE;
            nxtFv    = 1'b1;
            nxtLv    = 1'b1;
            nxtPat   = iPattern;
          end else begin
            nxtState = IDLE;
          end
        end else begin
          nxtBlank = blankCnt + 1'b1;
        end
      end
      default: nxtState = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      blankCnt    <= '0;
      patSel      <= PAT_SOLID;
      frameCount  <= 16'h0000;
      oFrameValid <= 1'b0;
      oLineValid  <= 1'b0;
    end else begin
      state       <= nxtState;
      x           <= nxtX;
      y           <= nxtY;
      blankCnt    <= nxtBlank;
      patSel      <= nxtPat;
      frameCount  <= nxtCount;
      oFrameValid <= nxtFv;
      oLineValid  <= nxtLv;
    end
  end

  assign oFrameCount = frameCount;

  image_pattern_gen uPattern (
    .iClk     (iClk),
    .iRst     (iRst),
    .iActive  (nxtLv),
    .iX       (nxtX),
    .iY       (nxtY),
    .iFrame   (frameCount[7:0]),
    .iPattern (nxtPat),
    .oPixel   (oPixel)
  );

endmodule

// File: tb/tb_image_timing_gen.sv
// tb/tb_image_timing_gen.sv - scoreboard bench for image_timing_gen with a frame-level reference model
module tb_image_timing_gen;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int HB    = 2;
  localparam int VB    = 2;
  localparam int FRAME = (H + VB) * (W + HB);

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  pat;
  logic        fv;
  logic        lv;
  logic [23:0] pix;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  image_timing_gen #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .H_BLANK (HB),
    .V_BLANK (VB)
  ) dut (
    .iClk        (clk),
    .iRst        (rst),
    .iEnable     (en),
    .iPattern    (pat),
    .oFrameValid (fv),
    .oLineValid  (lv),
    .oPixel      (pix),
    .oFrameCount (cnt)
  );

  typedef struct {
    logic        fv;
    logic        lv;
    logic [23:0] pix;
    logic [15:0] cnt;
  } expT;

  expT         expQ[$];
  expT         monE;
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] mdlCount = 16'h0000;
  bit          started  = 1'b0;
  bit          sinkOn   = 1'b0;
  bit          sinkPeriod = 1'b0;

  function automatic logic [23:0] refPixel(input logic [1:0] p, input int xi, input int yi,
                                           input logic [15:0] f);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = xi[7:0];
    yb = yi[7:0];
    case (p)
      2'd0:    return 24'h808080;
      2'd1:    return {xb, xb, xb};
      2'd2:    return (xi[3] ^ yi[3]) ? 24'hFFFFFF : 24'h000000;
      default: return {f[7:0], xb, yb};
    endcase
  endfunction

  task automatic pushE(input logic f, input logic l, input logic [23:0] p, input logic [15:0] c);
    expT e;
    e.fv  = f;
    e.lv  = l;
    e.pix = p;
    e.cnt = c;
    expQ.push_back(e);
  endtask

  // One whole frame of expected outputs, built line by line from the frame rules.
  task automatic pushFrame(input logic [1:0] p);
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) pushE(1'b1, 1'b1, refPixel(p, xx, yy, mdlCount), mdlCount);
      for (int hh = 0; hh < HB; hh++) pushE(1'b1, 1'b0, 24'h0, mdlCount);
    end
    mdlCount = mdlCount + 16'd1;
    for (int vv = 0; vv < VB * (W + HB); vv++) pushE(1'b0, 1'b0, 24'h0, mdlCount);
  endtask

  // Reference model: inputs matter only on reset or when the previous frame/idle slot is used up.
  always @(posedge clk) begin
    if (rst) begin
      expQ.delete();
      mdlCount = 16'h0000;
      pushE(1'b0, 1'b0, 24'h0, 16'h0000);
      started = 1'b1;
    end else if (started && expQ.size() == 0) begin
      if (en) pushFrame(pat);
      else    pushE(1'b0, 1'b0, 24'h0, mdlCount);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t no expected entry for DUT output", $time);
      end else begin
        monE = expQ.pop_front();
        if ({fv, lv, pix, cnt} !== {monE.fv, monE.lv, monE.pix, monE.cnt}) begin
          failures++;
          $display("FAIL outputs t=%0t got fv=%b lv=%b pix=%h cnt=%h expected fv=%b lv=%b pix=%h cnt=%h",
                   $time, fv, lv, pix, cnt, monE.fv, monE.lv, monE.pix, monE.cnt);
        end
      end
    end
  end

  // Measuring sink: line width, lines per frame and frame period seen on the strobes.
  int   cyc = 0;
  int   lvRun = 0;
  int   lines = 0;
  int   lastRise = -1;
  logic prevLv = 1'b0;
  logic prevFv = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (lv) lvRun++;
    if (prevLv && !lv) begin
      if (sinkOn) begin
        checks++;
        if (lvRun != W) begin
          failures++;
          $display("FAIL sink_width got %0d expected %0d", lvRun, W);
        end
      end
      lines++;
      lvRun = 0;
    end
    if (!prevFv && fv) begin
      if (sinkPeriod && lastRise >= 0) begin
        checks++;
        if (cyc - lastRise != FRAME) begin
          failures++;
          $display("FAIL sink_period got %0d expected %0d", cyc - lastRise, FRAME);
        end
      end
      lastRise = cyc;
      lines = 0;
    end
    if (prevFv && !fv && sinkOn) begin
      checks++;
      if (lines != H) begin
        failures++;
        $display("FAIL sink_height got %0d expected %0d", lines, H);
      end
    end
    prevLv = lv;
    prevFv = fv;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    pat = 2'd0;
    tick(3);
    rst    = 1'b0;
    sinkOn = 1'b1;
    tick(2);

    // Continuous run, ramp pattern first, then pattern changes that only take effect per frame.
    pat = 2'd1;
    en  = 1'b1;
    tick(5);
    sinkPeriod = 1'b1;
    tick(40);
    for (int i = 0; i < 2 * FRAME; i++) begin
      pat = 2'($urandom_range(0, 3));
      tick(1);
    end
    sinkPeriod = 1'b0;
    en = 1'b0;
    tick(40);

    // Enable dropped during line 1: the frame and its vertical blank still complete.
    pat = 2'd2;
    en  = 1'b1;
    tick(8);
    en = 1'b0;
    tick(40);

    // Reset in the middle of line 1, then restart.
    sinkOn = 1'b0;
    pat = 2'd3;
    en  = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(35);
    en = 1'b0;
    tick(40);

    // Frame counter wrap from 0xFFFF.
    sinkOn = 1'b1;
    force dut.frameCount = 16'hFFFF;
    mdlCount = 16'hFFFF;
    for (int i = 0; i < expQ.size(); i++) expQ[i].cnt = 16'hFFFF;
    #1;
    release dut.frameCount;
    tick(1);
    en  = 1'b1;
    pat = 2'd3;
    tick(31);
    en = 1'b0;
    tick(40);

    // Randomized enable, pattern and occasional reset.
    sinkOn = 1'b0;
    for (int i = 0; i < 600; i++) begin
      en  = ($urandom_range(0, 9) < 7);
      pat = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 199) == 0);
      tick(1);
    end
    rst = 1'b0;
    en  = 1'b0;
    tick(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
